// File: rtl/stack_pkg.sv
// Shared types and defaults for the call-stack responder.
package stack_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_t;

endpackage

// File: rtl/stack_ram.sv
// Return-address storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack_responder.sv
// Responder for CALL/RET stack requests with req/ack handshake and fixed access latency.
// Build option: STACK_BOUNDS_CHECK_EN drops overflow/underflow accesses and flags stack_err.
//
// state     | meaning
// ST_IDLE   | waiting for push_req/pop_req
// ST_ACCESS | counting down access latency, commit on count 0
// ST_DONE   | req_ack (and stack_err) high for this one cycle
module call_stack_responder
    import stack_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 1,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_req,
    input  logic                     pop_req,
    input  logic [DATA_W-1:0]        push_data,
    output logic                     req_ack,
    output logic [DATA_W-1:0]        top_of_stack,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty,
    output logic                     stack_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHK = 1'b1;
`else
    localparam bit BOUNDS_CHK = 1'b0;
`endif

    state_t            state, state_nxt;
    op_t               op_q, op_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic [AW-1:0]     wptr, wptr_nxt;
    logic [SW-1:0]     sp_q, sp_nxt;
    logic              err_q, err_nxt;
    logic [DATA_W-1:0] top_q;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [AW-1:0]     top_addr;
    logic [DATA_W-1:0] rd_data;

    assign full     = (sp_q == SW'(DEPTH));
    assign empty    = (sp_q == '0);
    assign top_addr = wptr - AW'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_PUSH;
            cnt    <= '0;
            data_q <= '0;
            wptr   <= '0;
            sp_q   <= '0;
            err_q  <= 1'b0;
            top_q  <= '0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            cnt    <= cnt_nxt;
            data_q <= data_nxt;
            wptr   <= wptr_nxt;
            sp_q   <= sp_nxt;
            err_q  <= err_nxt;
            top_q  <= empty ? '0 : rd_data;
        end
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        cnt_nxt   = cnt;
        data_nxt  = data_q;
        wptr_nxt  = wptr;
        sp_nxt    = sp_q;
        err_nxt   = err_q;
        we        = 1'b0;
        waddr     = wptr;
        case (state)
            ST_IDLE, ST_DONE: begin
                // DONE also samples, so a held request restarts without an idle gap
                err_nxt   = 1'b0;
                state_nxt = ST_IDLE;
                if (push_req || pop_req) begin
                    op_nxt    = (push_req && pop_req) ? OP_REPLACE :
                                (push_req ? OP_PUSH : OP_POP);
                    data_nxt  = push_data;
                    cnt_nxt   = CW'(LATENCY - 1);
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    state_nxt = ST_DONE;
                    case (op_q)
                        OP_POP: begin
                            if (empty) begin
                                err_nxt = BOUNDS_CHK;
                            end else begin
                                wptr_nxt = wptr - AW'(1);
                                sp_nxt   = sp_q - SW'(1);
                            end
                        end
                        OP_REPLACE: begin
                            we = 1'b1;
                            if (empty) begin
                                wptr_nxt = wptr + AW'(1);
                                sp_nxt   = sp_q + SW'(1);
                            end else begin
                                waddr = top_addr;
                            end
                        end
                        default: begin
                            // full without bounds check: overwrite the oldest slot
                            if (full && BOUNDS_CHK) begin
                                err_nxt = 1'b1;
                            end else begin
                                we       = 1'b1;
                                wptr_nxt = wptr + AW'(1);
                                if (!full) sp_nxt = sp_q + SW'(1);
                            end
                        end
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    stack_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (data_q),
        .raddr (top_addr),
        .rdata (rd_data)
    );

    assign req_ack      = (state == ST_DONE);
    assign stack_err    = err_q;
    assign top_of_stack = top_q;
    assign sp           = sp_q;

endmodule

// File: tb/tb_call_stack_responder.sv
// Scoreboard bench for call_stack_responder (LATENCY=1 main instance, LATENCY=3 busy-window instance).
module tb_call_stack_responder;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int SW    = 5;
`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          push_req = 1'b0, pop_req = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          req_ack, full, empty, stack_err;
    logic [DW-1:0] top_of_stack;
    logic [SW-1:0] sp;

    logic          push_req3 = 1'b0, pop_req3 = 1'b0;
    logic [DW-1:0] push_data3 = '0;
    logic          req_ack3, full3, empty3, stack_err3;
    logic [DW-1:0] top3;
    logic [SW-1:0] sp3;

    always #5 clock = ~clock;

    call_stack_responder #(.DEPTH(DEPTH), .LATENCY(1), .DATA_W(DW)) u_dut (
        .clock(clock), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
        .push_data(push_data), .req_ack(req_ack), .top_of_stack(top_of_stack),
        .sp(sp), .full(full), .empty(empty), .stack_err(stack_err)
    );

    call_stack_responder #(.DEPTH(DEPTH), .LATENCY(3), .DATA_W(DW)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .push_req(push_req3), .pop_req(pop_req3),
        .push_data(push_data3), .req_ack(req_ack3), .top_of_stack(top3),
        .sp(sp3), .full(full3), .empty(empty3), .stack_err(stack_err3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] top;
        logic [31:0] sp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mstk[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle.
    task automatic do_req(input bit p, input bit q, input logic [31:0] d);
        exp_t e;
        int   cyc;
        bit   got;
        e.err = 1'b0;
        if (p && q) begin
            if (mstk.size() == 0) mstk.push_back(d);
            else mstk[mstk.size()-1] = d;
        end else if (p) begin
            if (mstk.size() == DEPTH) begin
                if (BCHK) e.err = 1'b1;
                else begin
                    mstk.delete(0);
                    mstk.push_back(d);
                end
            end else mstk.push_back(d);
        end else begin
            if (mstk.size() == 0) e.err = BCHK;
            else void'(mstk.pop_back());
        end
        e.sp  = mstk.size();
        e.top = (mstk.size() == 0) ? 32'h0 : mstk[mstk.size()-1];
        exp_q.push_back(e);

        push_req = p; pop_req = q; push_data = d;
        cyc = 0; got = 1'b0;
        while (cyc < 20 && !got) begin
            @(posedge clock); #1;
            cyc++;
            got = req_ack;
        end
        push_req = 1'b0; pop_req = 1'b0;
        check("ack_seen", {31'b0, got}, 32'd1);
        e = exp_q.pop_front();
        if (got) begin
            check("ack_latency", cyc, 32'd2);
            check("stack_err", {31'b0, stack_err}, {31'b0, e.err});
            @(posedge clock); #1;
            check("ack_one_cycle", {31'b0, req_ack}, 32'd0);
            check("top", top_of_stack, e.top);
            check("sp", {27'b0, sp}, e.sp);
            check("full", {31'b0, full}, {31'b0, e.sp == DEPTH});
            check("empty", {31'b0, empty}, {31'b0, e.sp == 0});
        end
    endtask

    initial begin
        int cyc;
        int acks;
        repeat (3) @(posedge clock);
        #1;
        check("rst_sp", {27'b0, sp}, 32'd0);
        check("rst_top", top_of_stack, 32'd0);
        check("rst_ack", {31'b0, req_ack}, 32'd0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // reset in the middle of an access aborts it
        push_req = 1'b1; push_data = 32'h55;
        @(posedge clock); #1;
        reset_n = 1'b0; push_req = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (req_ack) acks++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (req_ack) acks++;
        end
        check("abort_no_ack", acks, 32'd0);
        check("abort_sp", {27'b0, sp}, 32'd0);
        check("abort_top", top_of_stack, 32'd0);
        check("abort_empty", {31'b0, empty}, 32'd1);

        do_req(1, 0, 32'h100);
        do_req(1, 0, 32'h200);
        do_req(0, 1, 32'h0);
        do_req(0, 1, 32'h0);
        do_req(0, 1, 32'h0);
        do_req(1, 0, 32'h40);
        do_req(1, 1, 32'h80);
        do_req(0, 1, 32'h0);
        do_req(1, 1, 32'h33);
        do_req(0, 1, 32'h0);

        for (int i = 1; i <= 16; i++) do_req(1, 0, i);
        check("fill_full", {31'b0, full}, 32'd1);
        do_req(1, 0, 32'd17);
        check("overflow_top", top_of_stack, BCHK ? 32'd16 : 32'd17);
        for (int i = 0; i < 16; i++) do_req(0, 1, 32'h0);
        check("drained_empty", {31'b0, empty}, 32'd1);

        // LATENCY=3: request lines wiggle while busy, only one ack expected
        push_req3 = 1'b1; push_data3 = 32'hABC;
        cyc = 0;
        while (cyc < 20 && !req_ack3) begin
            @(posedge clock); #1;
            cyc++;
            if (!req_ack3) begin
                push_req3 = ~push_req3;
                pop_req3  = ~pop_req3;
            end
        end
        push_req3 = 1'b0; pop_req3 = 1'b0;
        check("lat3_ack_cycle", cyc, 32'd4);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (req_ack3) acks++;
        end
        check("lat3_single_ack", acks, 32'd0);
        check("lat3_top", top3, 32'hABC);
        check("lat3_sp", {27'b0, sp3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
